uart_tx_buffered: RTL and testbench

UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

---
 rtl/uart_pkg.sv | 19 +
 rtl/sync_fifo.sv | 52 +++++
 rtl/uart_tx_buffered.sv | 153 +++++++++++++++
 tb/tb_uart_tx_buffered.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the buffered UART transmitter.
// Holds the transmit FSM states and the parity mode selector.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data and occupancy count.
// Writes when full and reads when empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_wr;
  logic             w_rd;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rd_data = r_mem[r_rptr];
  assign w_wr      = i_wr_en && !o_full;
  assign w_rd      = i_rd_en && !o_empty;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= i_wr_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + {{AW{1'b0}}, w_wr}
                         - {{AW{1'b0}}, w_rd};
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// UART transmitter fed from a small input FIFO.
// Frames are sent back-to-back while words remain buffered.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int      DATA_BITS    = 8,
  parameter int      CLKS_PER_BIT = 16,
  parameter int      FIFO_DEPTH   = 4,
  parameter parity_e PARITY       = PAR_NONE,
  parameter int      STOP_BITS    = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_BITS-1:0]          in_data,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);

  tx_state_e              r_state, w_nstate;
  logic [CW-1:0]          r_baud, w_nbaud;
  logic [BW-1:0]          r_bit, w_nbit;
  logic [DATA_BITS-1:0]   r_shift, w_nshift;
  logic                   r_par, w_npar;
  logic                   r_tx, w_ntx;
  logic                   w_tick;
  logic                   w_pop;
  logic                   w_wr;
  logic                   w_full;
  logic                   w_empty;
  logic [DATA_BITS-1:0]   w_rd_data;

  assign in_ready = !w_full;
  assign w_wr     = in_valid && in_ready;
  assign tx       = r_tx;
  assign busy     = (r_state != ST_IDLE);

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_wr),
    .i_wr_data (in_data),
    .i_rd_en   (w_pop),
    .o_rd_data (w_rd_data),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (fifo_count)
  );

  // Next line level is computed with the transition so tx stays registered.
  always_comb begin
    w_nstate = r_state;
    w_nbaud  = r_baud;
    w_nbit   = r_bit;
    w_nshift = r_shift;
    w_npar   = r_par;
    w_ntx    = r_tx;
    w_pop    = 1'b0;
    w_tick   = (r_baud == CW'(CLKS_PER_BIT-1));
    if (r_state != ST_IDLE)
      w_nbaud = w_tick ? '0 : r_baud + 1'b1;
    unique case (r_state)
      ST_IDLE: begin
        if (!w_empty) w_pop = 1'b1;
      end
      ST_START: begin
        if (w_tick) begin
          w_nstate = ST_DATA;
          w_nbit   = '0;
          w_ntx    = r_shift[0];
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          if (r_bit == BW'(DATA_BITS-1)) begin
            w_nbit = '0;
            if (PARITY != PAR_NONE) begin
              w_nstate = ST_PARITY;
              w_ntx    = r_par;
            end else begin
              w_nstate = ST_STOP;
              w_ntx    = 1'b1;
            end
          end else begin
            w_nbit   = r_bit + 1'b1;
            w_nshift = r_shift >> 1;
            w_ntx    = r_shift[1];
          end
        end
      end
      ST_PARITY: begin
        if (w_tick) begin
          w_nstate = ST_STOP;
          w_nbit   = '0;
          w_ntx    = 1'b1;
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          if (r_bit == BW'(STOP_BITS-1)) begin
            if (!w_empty) begin
              w_pop = 1'b1;
            end else begin
              w_nstate = ST_IDLE;
              w_ntx    = 1'b1;
            end
          end else begin
            w_nbit = r_bit + 1'b1;
          end
        end
      end
      default: begin
        w_nstate = ST_IDLE;
        w_ntx    = 1'b1;
      end
    endcase
    if (w_pop) begin
      w_nstate = ST_START;
      w_nshift = w_rd_data;
      w_npar   = (^w_rd_data) ^ (PARITY == PAR_ODD);
      w_nbit   = '0;
      w_nbaud  = '0;
      w_ntx    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_nstate;
      r_baud  <= w_nbaud;
      r_bit   <= w_nbit;
      r_shift <= w_nshift;
      r_par   <= w_npar;
      r_tx    <= w_ntx;
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: scoreboarded frames on an even-parity
// instance plus directed frames on odd-parity and 5-bit/2-stop instances.
module tb_uart_tx_buffered;
  import uart_pkg::*;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       a_valid = 1'b0;
  logic       a_ready;
  logic [7:0] a_data = '0;
  logic       a_tx, a_busy;
  logic [2:0] a_cnt;

  logic       b_valid = 1'b0;
  logic       b_ready;
  logic [7:0] b_data = '0;
  logic       b_tx, b_busy;
  logic [2:0] b_cnt;

  logic       c_valid = 1'b0;
  logic       c_ready;
  logic [4:0] c_data = '0;
  logic       c_tx, c_busy;
  logic [2:0] c_cnt;

  uart_tx_buffered #(
    .DATA_BITS(8), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4),
    .PARITY(PAR_EVEN), .STOP_BITS(1)
  ) u_a (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_ready),
    .in_data(a_data), .tx(a_tx), .busy(a_busy), .fifo_count(a_cnt)
  );

  uart_tx_buffered #(
    .DATA_BITS(8), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4),
    .PARITY(PAR_ODD), .STOP_BITS(1)
  ) u_b (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready),
    .in_data(b_data), .tx(b_tx), .busy(b_busy), .fifo_count(b_cnt)
  );

  uart_tx_buffered #(
    .DATA_BITS(5), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4),
    .PARITY(PAR_NONE), .STOP_BITS(2)
  ) u_c (
    .clk(clk), .rst(rst), .in_valid(c_valid), .in_ready(c_ready),
    .in_data(c_data), .tx(c_tx), .busy(c_busy), .fifo_count(c_cnt)
  );

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [15:0] mk(input logic [8:0] d, input int nb,
                                     input parity_e p);
    logic [15:0] v;
    int k;
    int ones;
    v = '1;
    v[0] = 1'b0;
    k = 1;
    ones = 0;
    for (int i = 0; i < nb; i++) begin
      v[k] = d[i];
      ones += int'(d[i]);
      k++;
    end
    if (p == PAR_EVEN) v[k] = ones[0];
    if (p == PAR_ODD)  v[k] = ~ones[0];
    return v;
  endfunction

  logic [7:0] q[$];
  int         starts[$];
  int         frames = 0;
  int         cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin : mon
    logic [15:0] bits;
    logic [7:0]  w;
    forever begin
      @(negedge clk);
      if (!rst && a_tx === 1'b0) begin
        check("a_expected_frame", q.size() != 0, 1);
        w = (q.size() != 0) ? q.pop_front() : 8'h00;
        starts.push_back(cyc);
        bits = mk(w, 8, PAR_EVEN);
        for (int c = 0; c < 11*CPB; c++) begin
          if (c != 0) @(negedge clk);
          if (rst) break;
          check("a_tx_bit", a_tx, bits[c/CPB]);
          check("a_busy", a_busy, 1);
        end
        if (!rst) frames++;
      end
    end
  end

  task automatic wr_a(input logic [7:0] d);
    int t = 0;
    @(negedge clk);
    a_valid = 1'b1;
    a_data  = d;
    while (!a_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("a_write_accept", a_ready, 1);
    @(posedge clk);
    if (a_ready) q.push_back(d);
    #1 a_valid = 1'b0;
  endtask

  task automatic wr_b(input logic [7:0] d);
    @(negedge clk);
    b_valid = 1'b1;
    b_data  = d;
    @(posedge clk);
    #1 b_valid = 1'b0;
  endtask

  task automatic wr_c(input logic [4:0] d);
    @(negedge clk);
    c_valid = 1'b1;
    c_data  = d;
    @(posedge clk);
    #1 c_valid = 1'b0;
  endtask

  function automatic logic txof(input int sel);
    return (sel == 1) ? b_tx : c_tx;
  endfunction

  function automatic logic busyof(input int sel);
    return (sel == 1) ? b_busy : c_busy;
  endfunction

  task automatic chk_frame(input int sel, input logic [15:0] bits,
                           input int n, input string tag);
    int t = 0;
    while (txof(sel) !== 1'b0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_start"}, t < 100, 1);
    for (int c = 0; c < n*CPB; c++) begin
      if (c != 0) @(negedge clk);
      check(tag, txof(sel), bits[c/CPB]);
      check({tag, "_busy"}, busyof(sel), 1);
    end
    @(negedge clk);
    check({tag, "_end_tx"}, txof(sel), 1);
    check({tag, "_end_busy"}, busyof(sel), 0);
  endtask

  task automatic wait_frames(input int n);
    int t = 0;
    while (frames < n && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("frames_done", frames, n);
  endtask

  initial begin : stim
    int t;
    int base;
    int s;
    repeat (3) @(negedge clk);
    check("rst_tx", a_tx, 1);
    check("rst_busy", a_busy, 0);
    check("rst_cnt", a_cnt, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_ready", a_ready, 1);
    repeat (5) @(negedge clk);
    check("idle_tx", a_tx, 1);
    check("idle_busy", a_busy, 0);

    @(negedge clk);
    a_valid = 1'b1;
    a_data  = 8'h3C;
    @(posedge clk);
    q.push_back(8'h3C);
    #1 a_valid = 1'b0;
    check("lat_cnt1", a_cnt, 1);
    check("lat_tx_hi", a_tx, 1);
    @(posedge clk);
    #1;
    check("lat_tx_lo", a_tx, 0);
    check("lat_cnt0", a_cnt, 0);
    check("lat_busy", a_busy, 1);
    wait_frames(1);
    repeat (4) @(negedge clk);
    check("after1_busy", a_busy, 0);

    wr_a(8'hA5);
    wait_frames(2);

    wr_b(8'h07);
    chk_frame(1, mk(9'h07, 8, PAR_ODD), 11, "b07");
    wr_b(8'h03);
    chk_frame(1, mk(9'h03, 8, PAR_ODD), 11, "b03");
    wr_c(5'h1F);
    chk_frame(2, mk(9'h1F, 5, PAR_NONE), 8, "c1f");

    base = frames;
    wr_a(8'h11);
    t = 0;
    while (!a_busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    wr_a(8'h22);
    wr_a(8'h33);
    wr_a(8'h44);
    wr_a(8'h55);
    @(negedge clk);
    check("full_cnt", a_cnt, 4);
    check("full_ready", a_ready, 0);
    wr_a(8'h66);
    @(negedge clk);
    check("refill_cnt", a_cnt, 4);
    wait_frames(base + 6);
    for (int i = 0; i < 5; i++)
      if (starts.size() > base + i + 1)
        check("b2b_gap", starts[base+i+1] - starts[base+i], 11*CPB);
    check("starts_seen", starts.size(), base + 6);

    wr_a(8'h77);
    t = 0;
    while (a_tx !== 1'b0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    s = cyc;
    wr_a(8'h88);
    wr_a(8'h99);
    while (cyc - s < 10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_tx", a_tx, 1);
    check("mid_rst_busy", a_busy, 0);
    check("mid_rst_cnt", a_cnt, 0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    base = frames;
    repeat (100) @(negedge clk);
    check("post_rst_frames", frames, base);
    check("post_rst_tx", a_tx, 1);
    check("post_rst_busy", a_busy, 0);
    check("post_rst_ready", a_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
